// File: rtl/fifo_lane.sv
// rtl/fifo_lane.sv - single-lane byte FIFO feeding phy_tx, registered read port
// Optional sticky error flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_lane #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int AF_TH  = 3,
  parameter int AE_TH  = 1
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   fifo_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_TH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid_out;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Flags decode the registered count only, so push/pop never reach them combinationally.
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push && !w_full;
  assign w_pop_ok  = pop && !w_empty;

  assign fifo_count   = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_C);
  assign almost_empty = (r_count <= AE_C);
  assign data_out     = r_data_out;
  assign valid_out    = r_valid_out;

  // Storage is not reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk_f) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_valid_out <= w_pop_ok;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_err_overflow;
  logic r_err_underflow;

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (push && w_full) begin
        r_err_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lane.sv
// tb/tb_fifo_lane.sv - directed and randomized checks of fifo_lane against a queue model
module tb_fifo_lane;

  logic       clk_f = 1'b0;
  logic       reset_L;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic [2:0] fifo_count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       err_overflow;
  logic       err_underflow;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  logic [7:0] m_dout;
  logic       m_valid;
  logic       m_ovf;
  logic       m_unf;

  always #5 clk_f = ~clk_f;

  fifo_lane dut (
    .clk_f(clk_f),
    .reset_L(reset_L),
    .push(push),
    .data_in(data_in),
    .pop(pop),
    .data_out(data_out),
    .valid_out(valid_out),
    .fifo_count(fifo_count),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  task automatic check_all(input string where);
    int n;
    n = m_q.size();
    check({where, ".count"}, 32'(fifo_count), 32'(n));
    check({where, ".full"}, 32'(full), 32'(n == 4));
    check({where, ".empty"}, 32'(empty), 32'(n == 0));
    check({where, ".afull"}, 32'(almost_full), 32'(n >= 3));
    check({where, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
    check({where, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({where, ".dout"}, 32'(data_out), 32'(m_dout));
    check({where, ".ovf"}, 32'(err_overflow), 32'(m_ovf));
    check({where, ".unf"}, 32'(err_underflow), 32'(m_unf));
  endtask

  // Called at a falling edge: drive, let the rising edge happen, update the model, check.
  task automatic step(input string where, input logic p, input logic [7:0] d, input logic r);
    bit was_full;
    bit was_empty;
    push    = p;
    data_in = d;
    pop     = r;
    @(posedge clk_f);
    was_full  = (m_q.size() == 4);
    was_empty = (m_q.size() == 0);
    if (r && !was_empty) begin
      m_dout  = m_q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (p && !was_full) m_q.push_back(d);
    if (ERR_EN && p && was_full) m_ovf = 1'b1;
    if (ERR_EN && r && was_empty) m_unf = 1'b1;
    @(negedge clk_f);
    check_all(where);
  endtask

  task automatic async_reset(input string where);
    push = 1'b0;
    pop  = 1'b0;
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all(where);
    @(negedge clk_f);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [7:0] seq[4];
    logic [7:0] d;
    int pp;
    int rp;
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3; seq[3] = 8'hD4;
    reset_L = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = 8'h00;
    model_reset();
    @(negedge clk_f);
    check_all("reset");
    reset_L = 1'b1;

    for (int i = 0; i < 4; i++) step("fill", 1'b1, seq[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      check("drain.order", 32'(data_out), 32'(seq[i]));
    end

    for (int i = 0; i < 4; i++) step("refill", 1'b1, 8'($urandom), 1'b0);
    step("ovf_push", 1'b1, 8'hEE, 1'b0);
    step("full_pushpop", 1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 4; i++) step("ovf_drain", 1'b0, 8'h00, 1'b1);

    step("empty_pushpop", 1'b1, 8'h55, 1'b1);
    step("underflow_pop", 1'b0, 8'h00, 1'b1);
    check("underflow_pop.data", 32'(data_out), 32'h55);

    step("pre2a", 1'b1, 8'h10, 1'b0);
    step("pre2b", 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap", 1'b1, 8'(8'h20 + i), 1'b1);

    step("pre3", 1'b1, 8'h30, 1'b0);
    async_reset("async_rst");
    step("post_rst_push", 1'b1, 8'h77, 1'b0);
    step("post_rst_pop", 1'b0, 8'h00, 1'b1);
    check("post_rst.data", 32'(data_out), 32'h77);

    for (int i = 0; i < 600; i++) begin
      pp = (i < 200) ? 70 : (i < 400) ? 30 : 50;
      rp = (i < 200) ? 30 : (i < 400) ? 70 : 50;
      d  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_rst");
      end else begin
        step("rand", ($urandom_range(0, 99) < pp), d, ($urandom_range(0, 99) < rp));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
